cam_capture: RTL and testbench
==============================

CAM_CAPTURE -- requirements
Module: cam_capture

Interface
REQ-001 Parameter IMG_W, default 160, pixels per line.
REQ-002 Parameter IMG_H, default 120, lines per frame.
REQ-003 clk  input  1  system clock; the only clock in the block.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  one-cycle pulse that arms capture of the next frame.
REQ-006 abort  input  1  one-cycle pulse that cancels a capture.
REQ-007 cam_vsync  input  1  camera VSYNC, asynchronous to clk, high during frame blanking.
REQ-008 cam_href  input  1  camera HREF, asynchronous, high while line bytes are valid.
REQ-009 cam_pclk  input  1  camera pixel clock, asynchronous to clk.
REQ-010 cam_data  input  8  camera byte bus, valid at the cam_pclk rising edge.
REQ-011 cam_xclk  output  1  camera master clock.
REQ-012 ram_we  output  1  frame-RAM write strobe, one cycle per pixel.
REQ-013 ram_addr  output  19  frame-RAM write address.
REQ-014 ram_data  output  8  frame-RAM write byte.
REQ-015 busy  output  1  high in ARM, WAIT_FALL and CAPTURE.
REQ-016 done  output  1  high in DONE.
REQ-017 pix_count  output  19  pixels written in the current or last frame.
REQ-018 frame_err  output  1  sticky error flag for the current frame.

Function
REQ-019 cam_xclk SHALL toggle every clk cycle, giving clk/2.
- cam_vsync, cam_href, cam_pclk and cam_data SHALL each pass through two clk flops, all sharing the same pipeline.
- pclk_rise = synced pclk high AND prior synced pclk low.
- clk SHALL be at least 4x cam_pclk.
REQ-020 The FSM SHALL have states IDLE, ARM, WAIT_FALL, CAPTURE and DONE; reset state is IDLE.
REQ-021 IDLE/DONE -> ARM on start.
- On entry to ARM, pix_count, frame_err and the byte phase SHALL clear and done SHALL drop.
REQ-022 ARM -> WAIT_FALL on synced vsync high; WAIT_FALL -> CAPTURE on synced vsync low.
REQ-023 In CAPTURE, each pclk_rise with synced href high SHALL toggle the byte phase.
- Phase 0 latches the high byte.
- Phase 1 completes a 16-bit RGB565 word {hi, lo}.
REQ-024 On word completion, ram_we SHALL pulse exactly one cycle, on the clk cycle after that pclk_rise.
- ram_addr = pix_count before increment; ram_data = {R[4:2], G[5:3], B[4:3]} (RGB332).
- pix_count SHALL increment in the same cycle.
REQ-025 Synced href low SHALL reset the byte phase to 0.
- A line ending on phase 1 (odd byte count) SHALL set frame_err; the dangling byte is discarded.
REQ-026 When pix_count equals IMG_W*IMG_H, further words SHALL NOT write and SHALL NOT increment pix_count, and frame_err SHALL set.
REQ-027 CAPTURE -> DONE on synced vsync rising; no write occurs in the transition cycle.
REQ-028 abort in ARM, WAIT_FALL or CAPTURE -> IDLE next cycle, with no further ram_we.
- pix_count and frame_err hold their values.
REQ-029 start in ARM, WAIT_FALL or CAPTURE SHALL be ignored.
- start and abort in the same cycle: abort wins.
REQ-030 Address arithmetic is 19-bit unsigned with no wrap; the limit is enforced by REQ-026.

Reset
REQ-031 While rst_n is low, the block SHALL hold the following reset values:
- state IDLE;
- ram_we, ram_addr, ram_data, pix_count: 0;
- busy, done, frame_err: 0;
- cam_xclk: 0;
- synchronizer flops: 0.
REQ-032 Reset asserted mid-capture SHALL stop writes immediately (asynchronously).
- After release, the block SHALL wait in IDLE for a new start.

Configuration
REQ-033 Macro CAM_CAPTURE_GRAY_EN selects the pixel format written to ram_data.
- Defined: ram_data = (R8 + 2*G8 + B8) >> 2, computed 10 bits wide, where R8 = {R,R[4:2]}, G8 = {G,G[5:4]}, B8 = {B,B[4:2]}.
- Not defined: ram_data = RGB332 per REQ-024.
- Timing is identical in both builds.

Verification
REQ-034 Build with IMG_W=4, IMG_H=2. After start, drive one vsync pulse, 2 lines of 8 bytes, then vsync high:
- 8 ram_we pulses, addresses 0..7, pix_count=8, done=1, frame_err=0.
REQ-035 Byte pair 0xF8,0x1F (R=31, G=0, B=31) -> ram_data 0xE3.
- With CAM_CAPTURE_GRAY_EN: (255+0+255)>>2 = 127 = 0x7F.
REQ-036 A line of 7 bytes -> 3 writes from that line, frame_err=1.
REQ-037 3 lines of 8 bytes -> exactly 8 writes, pix_count=8, frame_err=1.
REQ-038 abort after the 3rd write -> IDLE, no more ram_we for the rest of the frame, pix_count=3.
- A following start clears pix_count to 0.
REQ-039 rst_n pulsed low mid-line -> all outputs 0 within the same cycle.
- Vsync edges then produce no writes until start.

Source files
------------

// File: rtl/cam_capture.sv
// ============================================================================
//  Module      : cam_capture
//  Description : Captures one RGB565 frame from a parallel camera port and
//                writes one converted byte per pixel into a frame RAM. The
//                camera signals are asynchronous; all of them are resampled
//                in the clk domain through a shared two-flop pipeline.
//                Optional build macro CAM_CAPTURE_GRAY_EN selects an 8-bit
//                grayscale output instead of RGB332.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cam_capture #(
    parameter int IMG_W = 160,
    parameter int IMG_H = 120
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        abort,
    input  logic        cam_vsync,
    input  logic        cam_href,
    input  logic        cam_pclk,
    input  logic [7:0]  cam_data,
    output logic        cam_xclk,
    output logic        ram_we,
    output logic [18:0] ram_addr,
    output logic [7:0]  ram_data,
    output logic        busy,
    output logic        done,
    output logic [18:0] pix_count,
    output logic        frame_err
);

    // Number of pixels that fit in one frame; writes beyond this are dropped.
    localparam int          c_PIX_TOTAL = IMG_W * IMG_H;
    localparam logic [18:0] c_PIX_MAX   = 19'(c_PIX_TOTAL);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_ARM       = 3'd1,
        S_WAIT_FALL = 3'd2,
        S_CAPTURE   = 3'd3,
        S_DONE      = 3'd4
    } state_t;

    state_t      r_state;

    // Resampling pipeline for the camera-domain signals.
    logic        r_vsync_s1;
    logic        r_vsync_s2;
    logic        r_vsync_s3;
    logic        r_href_s1;
    logic        r_href_s2;
    logic        r_pclk_s1;
    logic        r_pclk_s2;
    logic        r_pclk_s3;
    logic [7:0]  r_data_s1;
    logic [7:0]  r_data_s2;

    // Capture datapath state.
    logic        r_phase;
    logic [7:0]  r_hi;
    logic        r_xclk;
    logic        r_ram_we;
    logic [18:0] r_ram_addr;
    logic [7:0]  r_ram_data;
    logic        r_busy;
    logic        r_done;
    logic [18:0] r_pix_count;
    logic        r_frame_err;

    logic        w_pclk_rise;
    logic        w_vsync_rise;
    logic [7:0]  w_pix;

    // Edge detectors work on the resampled copies, so each camera edge is
    // seen exactly once in the clk domain.
    assign w_pclk_rise  = r_pclk_s2 & ~r_pclk_s3;
    assign w_vsync_rise = r_vsync_s2 & ~r_vsync_s3;

`ifdef CAM_CAPTURE_GRAY_EN
    // Grayscale: expand each channel to 8 bits by replicating its MSBs, then
    // weight green twice: (R8 + 2*G8 + B8) / 4. The word is {r_hi, lo}.
    logic [7:0]  w_r8;
    logic [7:0]  w_g8;
    logic [7:0]  w_b8;
    logic [9:0]  w_gray_sum;
    logic        w_unused_gray_lsbs;

    assign w_r8       = {r_hi[7:3], r_hi[7:5]};
    assign w_g8       = {r_hi[2:0], r_data_s2[7:5], r_hi[2:1]};
    assign w_b8       = {r_data_s2[4:0], r_data_s2[4:2]};
    assign w_gray_sum = {2'b00, w_r8} + {1'b0, w_g8, 1'b0} + {2'b00, w_b8};
    assign w_pix      = w_gray_sum[9:2];
    assign w_unused_gray_lsbs = ^w_gray_sum[1:0];
`else
    // RGB332: R[4:2] = hi[7:5], G[5:3] = hi[2:0], B[4:3] = lo[4:3].
    logic        w_unused_rgb_bits;

    assign w_pix = {r_hi[7:5], r_hi[2:0], r_data_s2[4:3]};
    assign w_unused_rgb_bits = ^r_hi[4:3];
`endif

    // Two-flop resampling of every camera input plus one history flop for
    // edge detection on pclk and vsync.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vsync_s1 <= 1'b0;
            r_vsync_s2 <= 1'b0;
            r_vsync_s3 <= 1'b0;
            r_href_s1  <= 1'b0;
            r_href_s2  <= 1'b0;
            r_pclk_s1  <= 1'b0;
            r_pclk_s2  <= 1'b0;
            r_pclk_s3  <= 1'b0;
            r_data_s1  <= 8'h00;
            r_data_s2  <= 8'h00;
        end else begin
            r_vsync_s1 <= cam_vsync;
            r_vsync_s2 <= r_vsync_s1;
            r_vsync_s3 <= r_vsync_s2;
            r_href_s1  <= cam_href;
            r_href_s2  <= r_href_s1;
            r_pclk_s1  <= cam_pclk;
            r_pclk_s2  <= r_pclk_s1;
            r_pclk_s3  <= r_pclk_s2;
            r_data_s1  <= cam_data;
            r_data_s2  <= r_data_s1;
        end
    end

    // Camera master clock: divide clk by two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_xclk <= 1'b0;
        end else begin
            r_xclk <= ~r_xclk;
        end
    end

    // Capture state machine with registered status and RAM-write outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_phase     <= 1'b0;
            r_hi        <= 8'h00;
            r_ram_we    <= 1'b0;
            r_ram_addr  <= 19'd0;
            r_ram_data  <= 8'h00;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_pix_count <= 19'd0;
            r_frame_err <= 1'b0;
        end else begin
            // The write strobe is a single-cycle pulse unless re-armed below.
            r_ram_we <= 1'b0;

            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start && !abort) begin
                        r_state     <= S_ARM;
                        r_pix_count <= 19'd0;
                        r_frame_err <= 1'b0;
                        r_phase     <= 1'b0;
                        r_done      <= 1'b0;
                        r_busy      <= 1'b1;
                    end
                end

                // Wait for the blanking interval that precedes the frame.
                S_ARM: begin
                    if (abort) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end else if (r_vsync_s2) begin
                        r_state <= S_WAIT_FALL;
                    end
                end

                // Frame data starts once vsync falls.
                S_WAIT_FALL: begin
                    if (abort) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end else if (!r_vsync_s2) begin
                        r_state <= S_CAPTURE;
                    end
                end

                S_CAPTURE: begin
                    if (abort) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end else if (w_vsync_rise) begin
                        // End of frame; a half-assembled word is dropped.
                        r_state <= S_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else if (!r_href_s2) begin
                        // Between lines: a pending high byte means the line
                        // had an odd number of bytes.
                        if (r_phase) begin
                            r_frame_err <= 1'b1;
                        end
                        r_phase <= 1'b0;
                    end else if (w_pclk_rise) begin
                        if (!r_phase) begin
                            r_hi    <= r_data_s2;
                            r_phase <= 1'b1;
                        end else begin
                            r_phase <= 1'b0;
                            if (r_pix_count == c_PIX_MAX) begin
                                // Frame already full: drop the word.
                                r_frame_err <= 1'b1;
                            end else begin
                                r_ram_we    <= 1'b1;
                                r_ram_addr  <= r_pix_count;
                                r_ram_data  <= w_pix;
                                r_pix_count <= r_pix_count + 19'd1;
                            end
                        end
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign cam_xclk  = r_xclk;
    assign ram_we    = r_ram_we;
    assign ram_addr  = r_ram_addr;
    assign ram_data  = r_ram_data;
    assign busy      = r_busy;
    assign done      = r_done;
    assign pix_count = r_pix_count;
    assign frame_err = r_frame_err;

endmodule

`default_nettype wire

// File: tb/tb_cam_capture.sv
// ============================================================================
//  Module      : tb_cam_capture
//  Description : Directed self-checking bench for cam_capture with a 4x2
//                frame. Camera timing is generated asynchronously with
//                clk = 8x pclk.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_cam_capture;

    logic        clk       = 1'b0;
    logic        rst_n     = 1'b0;
    logic        start     = 1'b0;
    logic        abort     = 1'b0;
    logic        cam_vsync = 1'b0;
    logic        cam_href  = 1'b0;
    logic        cam_pclk  = 1'b0;
    logic [7:0]  cam_data  = 8'h00;
    logic        cam_xclk;
    logic        ram_we;
    logic [18:0] ram_addr;
    logic [7:0]  ram_data;
    logic        busy;
    logic        done;
    logic [18:0] pix_count;
    logic        frame_err;

    int          n_checks = 0;
    int          n_fail   = 0;

    logic [18:0] wr_addr [$];
    logic [7:0]  wr_data [$];
    logic [7:0]  pat [0:31];

    cam_capture #(
        .IMG_W (4),
        .IMG_H (2)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .abort     (abort),
        .cam_vsync (cam_vsync),
        .cam_href  (cam_href),
        .cam_pclk  (cam_pclk),
        .cam_data  (cam_data),
        .cam_xclk  (cam_xclk),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_data  (ram_data),
        .busy      (busy),
        .done      (done),
        .pix_count (pix_count),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    // Log every RAM write, sampled on the falling edge.
    always @(negedge clk) begin
        if (ram_we === 1'b1) begin
            wr_addr.push_back(ram_addr);
            wr_data.push_back(ram_data);
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Expected RAM byte for a {hi, lo} RGB565 pair.
    function automatic logic [7:0] exp_pix(input logic [7:0] hi, input logic [7:0] lo);
        int r, g, b;
        r = int'(hi) / 8;
        g = (int'(hi) % 8) * 8 + int'(lo) / 32;
        b = int'(lo) % 32;
`ifdef CAM_CAPTURE_GRAY_EN
        begin
            int r8, g8, b8;
            r8 = r * 8 + r / 4;
            g8 = g * 4 + g / 16;
            b8 = b * 8 + b / 4;
            return 8'((r8 + 2 * g8 + b8) / 4);
        end
`else
        return 8'((r / 4) * 32 + (g / 8) * 4 + (b / 8));
`endif
    endfunction

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        #2;
    endtask

    task automatic pulse_abort();
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        #2;
    endtask

    task automatic cam_byte(input logic [7:0] b);
        cam_data = b;
        #40 cam_pclk = 1'b1;
        #40 cam_pclk = 1'b0;
    endtask

    task automatic cam_line(input int off, input int n);
        cam_href = 1'b1;
        #20;
        for (int i = 0; i < n; i++) cam_byte(pat[off + i]);
        #20 cam_href = 1'b0;
        #100;
    endtask

    task automatic vsync_pulse();
        cam_vsync = 1'b1;
        #200 cam_vsync = 1'b0;
        #200;
    endtask

    task automatic wait_done(input string tag);
        for (int i = 0; i < 300 && done !== 1'b1; i++) @(negedge clk);
        check_eq(tag, done, 1);
    endtask

    task automatic clear_log();
        wr_addr.delete();
        wr_data.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   toggles;
        logic x_prev;
        logic found;

        pat = '{8'hF8, 8'h1F, 8'h07, 8'hE0, 8'hFF, 8'hFF, 8'h00, 8'h00,
                8'h12, 8'h34, 8'hAB, 8'hCD, 8'h5A, 8'hA5, 8'h80, 8'h01,
                8'h3C, 8'hC3, 8'h55, 8'hAA, 8'h0F, 8'hF0, 8'h11, 8'h22,
                8'h33, 8'h44, 8'h66, 8'h77, 8'h99, 8'h88, 8'hDE, 8'hAD};

        // ---------------- reset values ----------------
        #22;
        check_eq("rst_ram_we",    ram_we,    0);
        check_eq("rst_ram_addr",  ram_addr,  0);
        check_eq("rst_ram_data",  ram_data,  0);
        check_eq("rst_pix_count", pix_count, 0);
        check_eq("rst_busy",      busy,      0);
        check_eq("rst_done",      done,      0);
        check_eq("rst_frame_err", frame_err, 0);
        check_eq("rst_xclk",      cam_xclk,  0);
        #10 rst_n = 1'b1;

        // ---------------- cam_xclk = clk/2 ----------------
        @(negedge clk);
        x_prev  = cam_xclk;
        toggles = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (cam_xclk !== x_prev) toggles++;
            x_prev = cam_xclk;
        end
        check_eq("xclk_toggles", toggles, 10);

        // ---------------- nominal 2x8-byte frame ----------------
        clear_log();
        pulse_start();
        check_eq("arm_busy", busy, 1);
        check_eq("arm_done", done, 0);
        vsync_pulse();
        cam_line(0, 8);
        cam_line(8, 8);
        cam_vsync = 1'b1;
        wait_done("nom_done");
        check_eq("nom_writes", wr_addr.size(), 8);
        for (int i = 0; i < 8; i++) begin
            if (i < wr_addr.size()) begin
                check_eq($sformatf("nom_addr%0d", i), wr_addr[i], i);
                check_eq($sformatf("nom_data%0d", i), wr_data[i], exp_pix(pat[2*i], pat[2*i+1]));
            end
        end
        if (wr_data.size() > 0) begin
`ifdef CAM_CAPTURE_GRAY_EN
            check_eq("magenta_px", wr_data[0], 8'h7F);
`else
            check_eq("magenta_px", wr_data[0], 8'hE3);
`endif
        end
        check_eq("nom_pix_count", pix_count, 8);
        check_eq("nom_frame_err", frame_err, 0);
        check_eq("nom_busy",      busy,      0);

        // ---------------- odd-length line ----------------
        clear_log();
        pulse_start();
        check_eq("rearm_done_clr", done, 0);
        vsync_pulse();
        cam_line(0, 7);
        cam_vsync = 1'b1;
        wait_done("odd_done");
        check_eq("odd_writes",    wr_addr.size(), 3);
        check_eq("odd_pix_count", pix_count, 3);
        check_eq("odd_frame_err", frame_err, 1);
        if (wr_addr.size() >= 3) check_eq("odd_addr2", wr_addr[2], 2);

        // ---------------- overflow: 3 lines into 8 pixels ----------------
        clear_log();
        pulse_start();
        check_eq("ovf_err_clr", frame_err, 0);
        vsync_pulse();
        cam_line(0, 8);
        cam_line(8, 8);
        cam_line(16, 8);
        cam_vsync = 1'b1;
        wait_done("ovf_done");
        check_eq("ovf_writes",    wr_addr.size(), 8);
        check_eq("ovf_pix_count", pix_count, 8);
        check_eq("ovf_frame_err", frame_err, 1);
        if (wr_addr.size() >= 8) check_eq("ovf_last_addr", wr_addr[7], 7);

        // ---------------- abort after the third write ----------------
        clear_log();
        pulse_start();
        vsync_pulse();
        fork
            begin
                cam_line(0, 8);
                cam_line(8, 8);
                cam_vsync = 1'b1;
                #400;
            end
            begin
                for (int n = 0; n < 4000 && wr_addr.size() < 3; n++) @(negedge clk);
                pulse_abort();
            end
        join
        check_eq("abt_writes",    wr_addr.size(), 3);
        check_eq("abt_pix_count", pix_count, 3);
        check_eq("abt_busy",      busy, 0);
        check_eq("abt_done",      done, 0);
        pulse_start();
        check_eq("abt_restart_pix", pix_count, 0);
        check_eq("abt_restart_busy", busy, 1);
        pulse_abort();
        check_eq("abt_arm_idle", busy, 0);

        // ---------------- asynchronous reset mid-line ----------------
        clear_log();
        pulse_start();
        vsync_pulse();
        found = 1'b0;
        fork
            cam_line(0, 8);
            begin
                for (int n = 0; n < 4000 && !found; n++) begin
                    @(negedge clk);
                    if (ram_we === 1'b1 && ram_addr === 19'd1) found = 1'b1;
                end
                check_eq("rstmid_trigger", found, 1);
                #1 rst_n = 1'b0;
                #1;
                check_eq("rstmid_ram_we",    ram_we,    0);
                check_eq("rstmid_ram_addr",  ram_addr,  0);
                check_eq("rstmid_ram_data",  ram_data,  0);
                check_eq("rstmid_pix_count", pix_count, 0);
                check_eq("rstmid_busy",      busy,      0);
                #50 rst_n = 1'b1;
            end
        join
        clear_log();
        vsync_pulse();
        cam_line(0, 8);
        cam_vsync = 1'b1;
        #400;
        check_eq("post_rst_writes", wr_addr.size(), 0);
        check_eq("post_rst_busy",   busy, 0);
        check_eq("post_rst_done",   done, 0);
        check_eq("post_rst_pix",    pix_count, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
